// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage RISC-V core.
// Merges the load-use stall, EX branch redirect and data-memory wait into
// per-stage write enables and bubble controls. Owns the memory-wait FSM
// with its timeout, and saturating stall/flush performance counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic branch_effective;

  // The whole pipeline freezes on an outstanding memory access or after a timeout fault.
  always_comb begin
    freeze = 1'b0;
    if (state_q == FAULT) begin
      freeze = 1'b1;
    end else if (mem_req && !mem_ready) begin
      freeze = 1'b1;
    end
  end

  // Memory-wait FSM next state and timeout counter.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d  = MEM_WAIT;
          to_cnt_d = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d  = RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LIMIT) begin
          state_d = FAULT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d  = RUN;
        to_cnt_d = '0;
      end
    endcase
  end

  // Stage controls: reset forces NOPs, then freeze > branch > load-use > normal flow.
  always_comb begin
    pc_we            = 1'b1;
    if_id_we         = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    id_ex_we         = 1'b1;
    ex_mem_we        = 1'b1;
    mem_wb_bubble    = 1'b0;
    branch_effective = 1'b0;
    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush      = 1'b1;
      id_ex_bubble     = 1'b1;
      branch_effective = 1'b1;
    end else if (load_use_stall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Saturating performance counters; a stuck FAULT state is not counted as stall time.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we && (state_q != FAULT) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_effective && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, timeout and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout_err = (state_q == FAULT) && !rst;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl: a default instance and a
// CNT_W=4 instance share the same stimulus so counter saturation is visible.
module tb_pipeline_stall_ctrl;

  localparam logic [6:0] CTRL_NONE = 7'b1100110;
  localparam logic [6:0] CTRL_LU   = 7'b0001110;
  localparam logic [6:0] CTRL_BR   = 7'b1111110;
  localparam logic [6:0] CTRL_FRZ  = 7'b0000001;
  localparam logic [6:0] CTRL_RST  = 7'b0011001;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic       err;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loadUse = 1'b0;
  logic branch = 1'b0;
  logic memReq = 1'b0;
  logic memReady = 1'b0;

  logic pcWe, ifIdWe, ifIdFlush, idExBubble, idExWe, exMemWe, memWbBubble, timeoutErr;
  logic [31:0] stallCnt, flushCnt;

  logic sPcWe, sIfIdWe, sIfIdFlush, sIdExBubble, sIdExWe, sExMemWe, sMemWbBubble, sTimeoutErr;
  logic [3:0] sStallCnt, sFlushCnt;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  pipeline_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .load_use_stall(loadUse), .branch_taken(branch),
    .mem_req(memReq), .mem_ready(memReady),
    .pc_we(pcWe), .if_id_we(ifIdWe), .if_id_flush(ifIdFlush),
    .id_ex_bubble(idExBubble), .id_ex_we(idExWe), .ex_mem_we(exMemWe),
    .mem_wb_bubble(memWbBubble), .mem_timeout_err(timeoutErr),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  pipeline_stall_ctrl #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst),
    .load_use_stall(loadUse), .branch_taken(branch),
    .mem_req(memReq), .mem_ready(memReady),
    .pc_we(sPcWe), .if_id_we(sIfIdWe), .if_id_flush(sIfIdFlush),
    .id_ex_bubble(sIdExBubble), .id_ex_we(sIdExWe), .ex_mem_we(sExMemWe),
    .mem_wb_bubble(sMemWbBubble), .mem_timeout_err(sTimeoutErr),
    .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lu, input logic br,
                               input logic req, input logic rdy,
                               input logic [6:0] expCtrl, input logic expErr,
                               input string tag);
    expT e;
    @(negedge clk);
    rst      = r;
    loadUse  = lu;
    branch   = br;
    memReq   = req;
    memReady = rdy;
    e.tag  = tag;
    e.ctrl = expCtrl;
    e.err  = expErr;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    #1;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sbQ.pop_front();
      checkVal({e.tag, "_ctrl"},
               {25'd0, pcWe, ifIdWe, ifIdFlush, idExBubble, idExWe, exMemWe, memWbBubble},
               {25'd0, e.ctrl});
      checkVal({e.tag, "_err"}, {31'd0, timeoutErr}, {31'd0, e.err});
    end
  endtask

  task automatic step(input logic r, input logic lu, input logic br,
                      input logic req, input logic rdy,
                      input logic [6:0] expCtrl, input logic expErr, input string tag);
    applyStimulus(r, lu, br, req, rdy, expCtrl, expErr, tag);
    checkOutput();
  endtask

  task automatic checkCounters(input int expStall, input int expFlush, input string tag);
    int expSmall;
    @(posedge clk);
    #1;
    expSmall = (expStall > 15) ? 15 : expStall;
    checkVal({tag, "_stall"}, stallCnt, expStall);
    checkVal({tag, "_flush"}, flushCnt, expFlush);
    checkVal({tag, "_stallSmall"}, {28'd0, sStallCnt}, expSmall);
  endtask

  initial begin
    $display("[TB] start");

    step(1, 0, 0, 0, 0, CTRL_RST, 0, "reset");
    checkCounters(0, 0, "reset");
    step(0, 0, 0, 0, 0, CTRL_NONE, 0, "idle");

    // load-use for one cycle, then normal flow
    step(0, 1, 0, 0, 0, CTRL_LU, 0, "lu");
    step(0, 0, 0, 0, 0, CTRL_NONE, 0, "luAfter");
    checkCounters(1, 0, "lu");

    // branch wins over simultaneous load-use
    step(1, 0, 0, 0, 0, CTRL_RST, 0, "rst2");
    step(0, 1, 1, 0, 0, CTRL_BR, 0, "brLu");
    checkCounters(0, 1, "brLu");

    // three-cycle memory wait; single ready cycle is not frozen
    step(1, 0, 0, 0, 0, CTRL_RST, 0, "rst3");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, CTRL_FRZ, 0, "memWait");
    step(0, 0, 0, 1, 1, CTRL_NONE, 0, "memReady");
    step(0, 0, 0, 1, 1, CTRL_NONE, 0, "memSingle");
    checkCounters(3, 0, "memWait");

    // branch held during a two-cycle wait takes effect only on the ready cycle
    step(1, 0, 0, 0, 0, CTRL_RST, 0, "rst5");
    step(0, 0, 1, 1, 0, CTRL_FRZ, 0, "brFrz1");
    step(0, 0, 1, 1, 0, CTRL_FRZ, 0, "brFrz2");
    step(0, 0, 1, 1, 1, CTRL_BR, 0, "brRelease");
    step(0, 0, 0, 0, 0, CTRL_NONE, 0, "brAfter");
    checkCounters(2, 1, "brWait");

    // memory timeout: 1 RUN cycle + 16 MEM_WAIT cycles, then FAULT
    step(1, 0, 0, 0, 0, CTRL_RST, 0, "rst4");
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0, CTRL_FRZ, 0, "toWait");
    step(0, 0, 0, 1, 0, CTRL_FRZ, 1, "toFault");
    checkCounters(17, 0, "toFault");
    step(0, 0, 0, 1, 1, CTRL_FRZ, 1, "faultReady");
    step(0, 0, 1, 0, 0, CTRL_FRZ, 1, "faultBranch");
    checkCounters(17, 0, "faultHold");
    step(1, 0, 0, 0, 0, CTRL_RST, 0, "rstFault");
    step(0, 0, 0, 0, 0, CTRL_NONE, 0, "afterFault");

    // saturation on the 4-bit instance, then reset in the middle of a wait
    step(1, 0, 0, 0, 0, CTRL_RST, 0, "rst6");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, CTRL_LU, 0, "luSat");
    checkCounters(20, 0, "luSat");
    step(0, 0, 0, 1, 0, CTRL_FRZ, 0, "midWait1");
    step(0, 0, 0, 1, 0, CTRL_FRZ, 0, "midWait2");
    step(1, 0, 0, 1, 0, CTRL_RST, 0, "rstMidWait");
    checkCounters(0, 0, "rstMidWait");
    step(0, 0, 0, 1, 1, CTRL_NONE, 0, "afterMidRst");
    checkCounters(0, 0, "afterMidRst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
